// File: rtl/mem_fill_arbiter_if.sv
// Bundle between the fill arbiter, the two cache fill FSMs and main memory.
// slave = arbiter side, master = caches/memory side.
interface mem_fill_arbiter_if #(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int WORDS = 8
);
    localparam int WW = $clog2(WORDS);

    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          d_req;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          i_grant;
    logic          d_grant;
    logic [DW-1:0] fill_data;
    logic [WW-1:0] fill_word;
    logic          i_fill_valid;
    logic          d_fill_valid;
    logic          i_done;
    logic          d_done;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
               fill_data, fill_word, i_fill_valid, d_fill_valid, i_done, d_done
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, i_grant, d_grant,
               fill_data, fill_word, i_fill_valid, d_fill_valid, i_done, d_done
    );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Shares one pipelined memory between I-cache and D-cache fills; D-cache
// write-through stores go out as single-cycle writes.
//
// state   | meaning
// IDLE    | no owner; arbitrate (write > lone read > round-robin tie)
// FILL_I  | I-cache owns memory; issue and collect one block
// FILL_D  | D-cache owns memory; issue and collect one block
// WRITE_D | one-cycle D-cache store to memory
module mem_fill_arbiter #(
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input logic                clk,
    input logic                rst_n,
    mem_fill_arbiter_if.slave  bus
);
    localparam int WW = $clog2(WORDS);
    localparam int CW = WW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(WORDS);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE_D} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] ret_cnt_q, ret_cnt_d;
    logic          last_is_d_q, last_is_d_d;
    logic          i_grant_q, i_grant_d;
    logic          d_grant_q, d_grant_d;

    logic              filling, issuing, ret_hit, blk_done;
    logic [AW-WW-2:0]  fill_base;
    logic              unused_addr_bits;

    // Block-offset bits of the I address are replaced by the issue counter.
    assign unused_addr_bits = ^bus.i_addr[WW:0];

    always_comb begin
        filling     = (state_q == FILL_I) || (state_q == FILL_D);
        issuing     = filling && (issue_cnt_q < CNT_FULL);
        ret_hit     = filling && bus.mem_valid;
        blk_done    = ret_hit && (ret_cnt_q == CNT_LAST);
        fill_base   = (state_q == FILL_I) ? bus.i_addr[AW-1:WW+1] : bus.d_addr[AW-1:WW+1];

        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        last_is_d_d = last_is_d_q;

        case (state_q)
            IDLE: begin
                if (bus.d_req && bus.d_wr) begin
                    state_d = WRITE_D;
                end else if (bus.i_req && bus.d_req) begin
                    state_d     = last_is_d_q ? FILL_I : FILL_D;
                    last_is_d_d = !last_is_d_q;
                end else if (bus.i_req) begin
                    state_d     = FILL_I;
                    last_is_d_d = 1'b0;
                end else if (bus.d_req) begin
                    state_d     = FILL_D;
                    last_is_d_d = 1'b1;
                end
            end
            FILL_I, FILL_D: begin
                if (issuing) issue_cnt_d = issue_cnt_q + CW'(1);
                if (ret_hit) ret_cnt_d   = ret_cnt_q + CW'(1);
                if (blk_done) begin
                    state_d     = IDLE;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            WRITE_D: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        i_grant_d = (state_d == FILL_I);
        d_grant_d = (state_d == FILL_D) || (state_d == WRITE_D);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            last_is_d_q <= 1'b0;
            i_grant_q   <= 1'b0;
            d_grant_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            last_is_d_q <= last_is_d_d;
            i_grant_q   <= i_grant_d;
            d_grant_q   <= d_grant_d;
            // A memory slower than MEM_LAT would leave more reads in flight than the pipe expects.
            if (filling) assert (int'(issue_cnt_q) - int'(ret_cnt_q) <= MEM_LAT);
        end
    end

    assign bus.mem_en       = issuing || (state_q == WRITE_D);
    assign bus.mem_wr       = (state_q == WRITE_D);
    assign bus.mem_addr     = (state_q == WRITE_D) ? bus.d_addr :
                              issuing ? {fill_base, issue_cnt_q[WW-1:0], 1'b0} : '0;
    assign bus.mem_wdata    = (state_q == WRITE_D) ? bus.d_wdata : '0;
    assign bus.i_grant      = i_grant_q;
    assign bus.d_grant      = d_grant_q;
    assign bus.fill_data    = ret_hit ? bus.mem_rdata : '0;
    assign bus.fill_word    = ret_hit ? ret_cnt_q[WW-1:0] : '0;
    assign bus.i_fill_valid = ret_hit && (state_q == FILL_I);
    assign bus.d_fill_valid = ret_hit && (state_q == FILL_D);
    assign bus.i_done       = blk_done && (state_q == FILL_I);
    assign bus.d_done       = (blk_done && (state_q == FILL_D)) || (state_q == WRITE_D);
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a fixed-latency pipelined memory model.
module tb_mem_fill_arbiter;
    localparam int AW = 16, DW = 16, WORDS = 8, MEM_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_fill_arbiter_if #(.AW(AW), .DW(DW), .WORDS(WORDS)) bus ();

    mem_fill_arbiter #(.WORDS(WORDS), .MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // memory model: read issued in cycle t returns in cycle t+MEM_LAT
    logic [MEM_LAT-1:0] pv = '0;
    logic [AW-1:0]      pa [MEM_LAT];
    logic               stray_v = 1'b0;
    logic [DW-1:0]      stray_d = '0;

    always @(posedge clk) begin
        pv    <= {pv[MEM_LAT-2:0], bus.mem_en & ~bus.mem_wr};
        pa[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pa[i] <= pa[i-1];
    end

    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    assign bus.mem_valid = pv[MEM_LAT-1] | stray_v;
    assign bus.mem_rdata = stray_v ? stray_d : mdata(pa[MEM_LAT-1]);

    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [58:0] outs();
        return {bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.i_grant, bus.d_grant,
                bus.fill_data, bus.fill_word, bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done};
    endfunction

    task automatic test_reset();
        bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0; bus.d_addr = '0; bus.d_wdata = '0;
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (outs() !== 59'd0) $display("FAIL reset_outs: got %h want 0", outs());
        else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (outs() !== 59'd0) $display("FAIL idle_outs: got %h want 0", outs());
        else n_pass++;
    endtask

    task automatic test_lone_i();
        logic [58:0] exp;
        logic [15:0] ea, ed;
        logic        een, efv;
        logic [2:0]  ew;
        bus.i_addr = 16'h1236;
        bus.i_req  = 1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            een = (k <= 8);
            ea  = een ? 16'h1230 + 16'(2 * (k - 1)) : 16'h0;
            efv = (k >= 5) && (k <= 12);
            ew  = efv ? 3'(k - 5) : 3'd0;
            ed  = efv ? mdata(16'h1230 + 16'(2 * (k - 5))) : 16'h0;
            exp = {een, 1'b0, ea, 16'h0, (k <= 12), 1'b0, ed, ew, efv, 1'b0, (k == 12), 1'b0};
            n_chk++;
            if (outs() !== exp) $display("FAIL lone_i cycle %0d: got %h want %h", k, outs(), exp);
            else n_pass++;
            if (bus.i_done) bus.i_req = 0;
        end
    endtask

    task automatic test_tie_alternation();
        int nw = 0, done_k = 0;
        bit seen;
        bus.i_addr = 16'h2000; bus.d_addr = 16'h4010; bus.d_wr = 0;
        bus.i_req = 1; bus.d_req = 1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (bus.d_fill_valid) begin
                n_chk++;
                if ({bus.fill_word, bus.fill_data} !== {3'(nw), mdata(16'h4010 + 16'(2 * nw))})
                    $display("FAIL tie_dword: got %0d/%h want %0d/%h", bus.fill_word, bus.fill_data, nw,
                             mdata(16'h4010 + 16'(2 * nw)));
                else n_pass++;
                nw++;
            end
            if (bus.d_done) begin done_k = k; bus.d_req = 0; end
            if (k == 1 || k == 13 || k == 14) begin
                n_chk++;
                if ({bus.i_grant, bus.d_grant} !== (k == 1 ? 2'b01 : k == 13 ? 2'b00 : 2'b10))
                    $display("FAIL tie_grants cycle %0d: got %b want %b", k, {bus.i_grant, bus.d_grant},
                             (k == 1 ? 2'b01 : k == 13 ? 2'b00 : 2'b10));
                else n_pass++;
            end
        end
        n_chk++;
        if (done_k != 12 || nw != 8) $display("FAIL tie_ddone: got cycle %0d words %0d want 12/8", done_k, nw);
        else n_pass++;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = bus.i_done;
        end
        n_chk++;
        if (!seen) $display("FAIL tie_idone: got none want pulse");
        else n_pass++;
        bus.d_req = 1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if ({bus.i_grant, bus.d_grant} !== 2'b01) $display("FAIL tie_alt: got %b want 01", {bus.i_grant, bus.d_grant});
        else n_pass++;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = bus.d_done;
        end
        bus.d_req = 0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = bus.i_done;
        end
        bus.i_req = 0;
        n_chk++;
        if (!seen) $display("FAIL tie_second_i: got none want i_done");
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write_priority();
        bit seen = 0;
        bus.i_addr = 16'h3000; bus.i_req = 1;
        bus.d_addr = 16'h00A4; bus.d_wdata = 16'hBEEF; bus.d_wr = 1; bus.d_req = 1;
        @(negedge clk);
        n_chk++;
        if ({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_grant, bus.i_grant, bus.d_done}
            !== {2'b11, 16'h00A4, 16'hBEEF, 3'b101})
            $display("FAIL write_cycle: got en%b wr%b a%h d%h g%b%b done%b want en1 wr1 a00a4 dbeef g10 done1",
                     bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.d_grant, bus.i_grant, bus.d_done);
        else n_pass++;
        bus.d_req = 0; bus.d_wr = 0;
        @(negedge clk);
        n_chk++;
        if ({bus.mem_en, bus.i_grant, bus.d_grant, bus.d_done} !== 4'b0000)
            $display("FAIL write_idle: got %b want 0000", {bus.mem_en, bus.i_grant, bus.d_grant, bus.d_done});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus.i_grant, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata} !== {3'b110, 16'h3000, 16'h0})
            $display("FAIL write_then_i: got g%b en%b wr%b a%h d%h want g1 en1 wr0 a3000 d0000",
                     bus.i_grant, bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata);
        else n_pass++;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = bus.i_done;
        end
        bus.i_req = 0;
        n_chk++;
        if (!seen) $display("FAIL write_i_done: got none want i_done");
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_req_during_fill();
        int nw = 0, done_k = 0;
        bit seen = 0;
        bus.i_addr = 16'h5550; bus.i_req = 1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 3) begin bus.d_addr = 16'h6000; bus.d_wr = 0; bus.d_req = 1; end
            if (bus.i_fill_valid) begin
                n_chk++;
                if (bus.fill_word !== 3'(nw)) $display("FAIL busy_word: got %0d want %0d", bus.fill_word, nw);
                else n_pass++;
                nw++;
            end
            if (bus.i_done) begin done_k = k; bus.i_req = 0; end
            n_chk++;
            if (bus.d_grant !== (k == 14)) $display("FAIL busy_dgrant cycle %0d: got %b want %b", k, bus.d_grant, (k == 14));
            else n_pass++;
        end
        n_chk++;
        if (done_k != 12 || nw != 8) $display("FAIL busy_idone: got cycle %0d words %0d want 12/8", done_k, nw);
        else n_pass++;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            seen = bus.d_done;
        end
        bus.d_req = 0;
        n_chk++;
        if (!seen) $display("FAIL busy_d_done: got none want d_done");
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        int bad = 0, nw = 0;
        bus.i_addr = 16'h7000; bus.i_req = 1;
        for (int k = 1; k <= 7; k++) @(negedge clk);
        n_chk++;
        if ({bus.i_fill_valid, bus.fill_word} !== {1'b1, 3'd2})
            $display("FAIL rst_third_ret: got v%b w%0d want v1 w2", bus.i_fill_valid, bus.fill_word);
        else n_pass++;
        rst_n = 1'b0; bus.i_req = 0;
        #1;
        n_chk++;
        if (outs() !== 59'd0) $display("FAIL rst_mid_outs: got %h want 0", outs());
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.i_fill_valid | bus.d_fill_valid | bus.i_done | bus.d_done) bad++;
        end
        n_chk++;
        if (bad != 0) $display("FAIL rst_late_valid: got %0d bad cycles want 0", bad);
        else n_pass++;
        bus.i_req = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.i_fill_valid) nw++;
            if (k == 5) begin
                n_chk++;
                if ({bus.i_fill_valid, bus.fill_word, bus.fill_data} !== {1'b1, 3'd0, mdata(16'h7000)})
                    $display("FAIL rst_refill_first: got v%b w%0d d%h want v1 w0 d%h",
                             bus.i_fill_valid, bus.fill_word, bus.fill_data, mdata(16'h7000));
                else n_pass++;
            end
            if (k == 12) begin
                n_chk++;
                if (bus.i_done !== 1'b1 || nw != 8) $display("FAIL rst_refill_done: got done%b words %0d want done1 8", bus.i_done, nw);
                else n_pass++;
                bus.i_req = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stray_valid();
        stray_d = 16'h1234; stray_v = 1;
        #1;
        n_chk++;
        if ({bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done} !== 4'b0000)
            $display("FAIL stray_valid: got %b want 0000", {bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done});
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if ({bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done, bus.mem_en, bus.i_grant, bus.d_grant} !== 7'b0)
            $display("FAIL stray_next: got %b want 0000000",
                     {bus.i_fill_valid, bus.d_fill_valid, bus.i_done, bus.d_done, bus.mem_en, bus.i_grant, bus.d_grant});
        else n_pass++;
        stray_v = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_lone_i();
        test_tie_alternation();
        test_write_priority();
        test_req_during_fill();
        test_reset_mid_fill();
        test_stray_valid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end
endmodule
